// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : imm_pkg
//  Description: Shared immediate-generation types, widths and the extension
//               helper. The decode-stage immediate generator and the
//               register-file/ALU immediate path both use extend_imm().
//  Revision   : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int IMM_IN_W  = 8;
    localparam int IMM_OUT_W = 16;

    typedef logic [15:0] imm16_t;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_e;

    // Widen an 8-bit immediate to the 16-bit datapath. Sign mode replicates
    // bit 7 into the upper byte; zero mode fills the upper byte with 0s.
    function automatic imm16_t extend_imm(input logic [7:0] imm8,
                                          input ext_mode_e  mode);
        imm16_t result;
        if (mode == EXT_ZERO) begin
            result = {8'h00, imm8};
        end else begin
            result = {{8{imm8[7]}}, imm8};
        end
        return result;
    endfunction

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extend_comb.sv
`default_nettype none
// ============================================================================
//  Module     : imm_extend_comb
//  Description: Purely combinational immediate extender. Concatenates the two
//               instruction nibbles and sign- or zero-extends the result.
//  Ports      : upper     - high nibble (its MSB is the immediate sign bit)
//               lower     - low nibble
//               zext      - 0: sign extend, 1: zero extend
//               ext_value - unregistered extended immediate
//  Revision   : 1.0 - initial release
// ============================================================================
module imm_extend_comb #(
    parameter int IMM_IN_W  = imm_pkg::IMM_IN_W,
    parameter int IMM_OUT_W = imm_pkg::IMM_OUT_W
) (
    input  logic [IMM_IN_W/2-1:0] upper,
    input  logic [IMM_IN_W/2-1:0] lower,
    input  logic                  zext,
    output logic [IMM_OUT_W-1:0]  ext_value
);
    import imm_pkg::*;

    logic [IMM_IN_W-1:0] imm_raw;

    assign imm_raw = {upper, lower};

    generate
        if (IMM_IN_W == 8 && IMM_OUT_W == 16) begin : g_pkg_fn
            // Native datapath widths: share the package helper so this path
            // and the ALU immediate path cannot drift apart.
            assign ext_value = extend_imm(imm_raw, ext_mode_e'(zext));
        end else begin : g_generic
            // Any other legal width pair: the signed cast supplies the
            // sign-bit replication, the unsigned cast the zero fill.
            assign ext_value = zext ? IMM_OUT_W'(imm_raw)
                                    : IMM_OUT_W'($signed(imm_raw));
        end
    endgenerate

endmodule : imm_extend_comb
`default_nettype wire

// File: rtl/sign_extend.sv
`default_nettype none
// ============================================================================
//  Module     : sign_extend
//  Description: Registered immediate generator for the decode stage. The
//               extended immediate is captured one cycle after the nibbles
//               and mode are presented, and feeds the ALU B-operand mux.
//  Ports      : clk   - rising-edge clock
//               reset - asynchronous, active-high; clears imme at once
//               upper - high nibble of the immediate (bit 3 = sign)
//               lower - low nibble of the immediate
//               zext  - 0: sign extend, 1: zero extend
//               imme  - registered extended immediate
//  Revision   : 1.0 - initial release
// ============================================================================
module sign_extend #(
    parameter int IMM_IN_W  = imm_pkg::IMM_IN_W,
    parameter int IMM_OUT_W = imm_pkg::IMM_OUT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IMM_IN_W/2-1:0] upper,
    input  logic [IMM_IN_W/2-1:0] lower,
    input  logic                  zext,
    output logic [IMM_OUT_W-1:0]  imme
);
    import imm_pkg::*;

    // Reject width combinations the extender cannot represent.
    generate
        if (!(IMM_OUT_W >= IMM_IN_W && IMM_IN_W == 2 * imm_pkg::NIBBLE_W)) begin : g_bad_params
            $error("sign_extend: need IMM_OUT_W >= IMM_IN_W and IMM_IN_W == 2*NIBBLE_W");
        end
    endgenerate

    logic [IMM_OUT_W-1:0] ext_value;

    imm_extend_comb #(
        .IMM_IN_W  (IMM_IN_W),
        .IMM_OUT_W (IMM_OUT_W)
    ) u_imm_extend_comb (
        .upper     (upper),
        .lower     (lower),
        .zext      (zext),
        .ext_value (ext_value)
    );

    // Only state in the block: the output register. Reset is not
    // resynchronised here; the deassertion is expected to be clean upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imme <= '0;
        end else begin
            imme <= ext_value;
        end
    end

endmodule : sign_extend
`default_nettype wire

// File: tb/tb_sign_extend.sv
`default_nettype none
// ============================================================================
//  Module     : tb_sign_extend
//  Description: Self-checking bench for sign_extend. Directed vectors plus
//               randomized back-to-back traffic, compared against an
//               arithmetic reference model.
//  Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sign_extend;

    logic        clk;
    logic        reset;
    logic [3:0]  upper;
    logic [3:0]  lower;
    logic        zext;
    logic [15:0] imme;

    int n_checks;
    int n_fail;

    sign_extend dut (
        .clk   (clk),
        .reset (reset),
        .upper (upper),
        .lower (lower),
        .zext  (zext),
        .imme  (imme)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: numeric value of the byte, read as signed -128..127 in
    // sign mode or unsigned 0..255 in zero mode, then taken modulo 2^16.
    function automatic logic [15:0] model(input int u, input int l, input bit z);
        int v;
        v = u * 16 + l;
        if (!z && v >= 128) v = v - 256;
        if (v < 0) v = v + 65536;
        return 16'(v);
    endfunction

    task automatic check_value(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Present inputs at the falling edge, check one rising edge later.
    task automatic apply(input string tag, input int u, input int l, input bit z);
        @(negedge clk);
        upper = 4'(u);
        lower = 4'(l);
        zext  = z;
        @(posedge clk);
        #1;
        check_value(tag, imme, model(u, l, z));
    endtask

    logic [15:0] out_a;
    logic [15:0] out_b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        upper    = 4'h0;
        lower    = 4'h0;
        zext     = 1'b0;
        reset    = 1'b1;

        // Reset held for 10 ns; output cleared before any clock edge.
        #2;
        check_value("reset_async", imme, 16'h0000);
        @(posedge clk);
        #1;
        upper = 4'hF;
        lower = 4'hF;
        check_value("reset_hold", imme, 16'h0000);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Directed values.
        apply("pos_16",     4'b0001, 4'b0000, 1'b0);
        check_value("pos_16_const", imme, 16'h0010);
        apply("neg_128",    4'b1000, 4'b0000, 1'b0);
        check_value("neg_128_const", imme, 16'hFF80);
        apply("neg_16",     4'b1111, 4'b0000, 1'b0);
        apply("neg_1",      4'b1111, 4'b1111, 1'b0);
        check_value("neg_1_const", imme, 16'hFFFF);
        apply("pos_6",      4'b0000, 4'b0110, 1'b0);
        apply("zext_f0",    4'b1111, 4'b0000, 1'b1);
        check_value("zext_f0_const", imme, 16'h00F0);
        apply("zext_81",    4'b1000, 4'b0001, 1'b1);
        check_value("zext_81_const", imme, 16'h0081);
        apply("zero_all",   4'b0000, 4'b0000, 1'b1);
        apply("pos_127",    4'b0111, 4'b1111, 1'b0);

        // Toggling the mode on identical inputs only touches bits [15:8].
        for (int i = 0; i < 8; i++) begin
            int u, l;
            u = int'($urandom_range(0, 15));
            l = int'($urandom_range(0, 15));
            apply("toggle_s", u, l, 1'b0);
            out_a = imme;
            apply("toggle_z", u, l, 1'b1);
            out_b = imme;
            check_value("toggle_xor", out_a ^ out_b, model(u, l, 1'b0) ^ model(u, l, 1'b1));
            check_value("toggle_low", {8'h00, out_a[7:0] ^ out_b[7:0]}, 16'h0000);
        end

        // Randomized back-to-back traffic with occasional mid-cycle changes.
        for (int i = 0; i < 300; i++) begin
            int u, l;
            bit z;
            u = int'($urandom_range(0, 15));
            l = int'($urandom_range(0, 15));
            z = 1'($urandom_range(0, 1));
            apply("rand", u, l, z);
            if ($urandom_range(0, 3) == 0) begin
                // Inputs change between edges; output must hold.
                #1;
                upper = 4'($urandom_range(0, 15));
                lower = 4'($urandom_range(0, 15));
                zext  = 1'($urandom_range(0, 1));
                #2;
                check_value("hold_mid", imme, model(u, l, z));
            end
        end

        // Asynchronous reset mid-stream.
        apply("pre_reset", 4'b1000, 4'b0000, 1'b0);
        check_value("pre_reset_const", imme, 16'hFF80);
        #2;
        reset = 1'b1;
        #1;
        check_value("reset_mid", imme, 16'h0000);
        @(negedge clk);
        upper = 4'h3;
        lower = 4'h5;
        zext  = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_value("post_reset", imme, model(3, 5, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sign_extend
`default_nettype wire

// File: doc/sign_extend.md
# sign_extend

Registered immediate generator for the processor's decode stage. It concatenates two 4-bit instruction fields, `upper` as the high nibble and `lower` as the low nibble, into an 8-bit immediate. It extends that immediate to the 16-bit datapath width, by sign extension by default or by zero extension on request. The result is registered and feeds the ALU B-operand mux.

## Interface
Parameters:
- `IMM_IN_W`, default 8: width of the concatenated immediate; must equal twice the nibble width.
- `IMM_OUT_W`, default 16: width of the extended output; must be at least `IMM_IN_W`.

Ports:
- `clk`, input, 1: single clock for the block; all state updates on the rising edge.
- `reset`, input, 1: asynchronous reset, active-high. Clears all state immediately, independent of `clk`.
- `upper`, input, 4: high nibble of the immediate; bit 3 is the immediate's sign bit.
- `lower`, input, 4: low nibble of the immediate.
- `zext`, input, 1: extension mode. 0 selects sign extension (default use). 1 selects zero extension.
- `imme`, output, 16: registered extended immediate.

## Operation
- Raw immediate: `imm8 = {upper, lower}`, so bit 7 equals `upper[3]`.
- When `zext = 0`: `imme` gets `{ {8{upper[3]}}, upper, lower }`, a two's-complement value in the range -128..+127.
- When `zext = 1`: `imme` gets `{ 8'h00, upper, lower }`, a value in the range 0..255.
- No other transformation is applied: no shift and no saturation.
- The upper 8 bits of `imme` always equal all 0s or all 1s. They are all 1s only when `zext = 0` and `upper[3] = 1`.
- No state is kept beyond the output register. There are no FSM states.
- Any input value, including X-free all-ones or all-zeros, produces a defined output. There are no illegal encodings.

## Timing
- Latency is 1 cycle. `imme` reflects `upper`, `lower` and `zext` as sampled at the previous rising edge of `clk`.
- The block accepts new inputs every cycle. There is no handshake and no stall.
- Reset value: `imme = 16'h0000`.
- Reset behaviour:
  - Asserting `reset` forces `imme` to 0 asynchronously, including mid-cycle.
  - While `reset` is high, clock edges do not update `imme`.
- Leaving reset: the first rising edge after `reset` deasserts captures the inputs present at that edge. Deassertion must be synchronised upstream; the block does not resynchronise it.
- Inputs that change between edges have no effect on `imme` until the next edge. The output never glitches between edges.

## Structure
- Shared package `imm_pkg` holds:
  - `NIBBLE_W = 4`, `IMM_IN_W = 8`, `IMM_OUT_W = 16`.
  - typedef `imm16_t` (logic [15:0]).
  - enum `ext_mode_e` with values `EXT_SIGN = 0` and `EXT_ZERO = 1`.
  - pure function `extend_imm(imm8, mode)` returning `imm16_t`. The register-file/ALU immediate path reuses the same function.
- One combinational sub-module is natural: `imm_extend_comb`. It takes `upper`, `lower` and `zext` and produces the unregistered 16-bit value. The top level adds only the asynchronously reset output register.
- The top level also carries parameter legality checks: an elaboration assertion that `IMM_OUT_W >= IMM_IN_W` and `IMM_IN_W == 2*NIBBLE_W`.

## Test plan
- Reset: pulse `reset` high for 10 ns with `upper = 0` and `lower = 0`. `imme = 16'h0000` immediately and stays 0 across clock edges while reset is high.
- Positive value: with `zext = 0`, `upper = 4'b0001` and `lower = 4'b0000`. After one edge `imme = 16'h0010` (+16).
- Negative values: with `zext = 0`:
  - `upper = 4'b1000`, `lower = 0` gives `16'hFF80` (-128).
  - `upper = 4'b1111`, `lower = 0` gives `16'hFFF0` (-16).
  - `upper = 4'b1111`, `lower = 4'b1111` gives `16'hFFFF` (-1).
  - `upper = 0`, `lower = 4'b0110` gives `16'h0006` (+6).
  - Each result appears one cycle after the inputs are applied.
- Zero extension: with `zext = 1`:
  - `upper = 4'b1111`, `lower = 0` gives `16'h00F0`.
  - `upper = 4'b1000`, `lower = 4'b0001` gives `16'h0081`.
  - Toggling `zext` on identical inputs flips only bits [15:8].
- Latency and hold:
  - Change the inputs mid-cycle: `imme` is unchanged until the next rising edge.
  - Change the inputs on back-to-back cycles: each value appears exactly one cycle later, with no dropped values.
- Reset mid-stream: while `imme = 16'hFF80`, assert `reset` asynchronously between edges. `imme` goes to `16'h0000` without waiting for a clock edge. After deassertion, the next edge loads the current inputs.
